// File: rtl/i2c_native_register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_regfile_pkg
// Description : Address map, STATUS/CONFIG bit indices and the cfg_t struct
//               shared by the I2C native register file.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_regfile_pkg;

    localparam logic [2:0] c_addr_data      = 3'd0;
    localparam logic [2:0] c_addr_read_len  = 3'd1;
    localparam logic [2:0] c_addr_write_len = 3'd2;
    localparam logic [2:0] c_addr_clk_div   = 3'd3;
    localparam logic [2:0] c_addr_config    = 3'd4;
    localparam logic [2:0] c_addr_status    = 3'd5;
    localparam logic [2:0] c_addr_bytes_rd  = 3'd6;
    localparam logic [2:0] c_addr_bytes_wr  = 3'd7;

    localparam int c_st_stop        = 0;
    localparam int c_st_din_full    = 1;
    localparam int c_st_din_empty   = 2;
    localparam int c_st_dout_full   = 3;
    localparam int c_st_slave_ack   = 4;
    localparam int c_st_slave_nack  = 5;
    localparam int c_st_bus_avail   = 6;
    localparam int c_st_arb_loss    = 7;
    localparam int c_st_rx_overrun  = 8;
    localparam int c_st_tx_overflow = 9;

    localparam int c_cfg_fifo_enable = 8;
    localparam int c_cfg_packet_type = 9;
    localparam int c_cfg_start       = 10;
    localparam int c_cfg_master_ack  = 11;
    localparam int c_cfg_master_nack = 12;
    localparam int c_cfg_sr_enable   = 13;

    typedef struct packed {
        logic sr_enable;
        logic master_nack;
        logic master_ack;
        logic start;
        logic packet_type;
        logic fifo_enable;
    } cfg_t;

endpackage
`default_nettype wire

// File: rtl/i2c_native_register_file_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_native_register_file_if
// Description : Host-side addressed 32-bit register port.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_native_register_file_if;

    logic [2:0]  reg_addr;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;

    modport master (
        output reg_addr, reg_wr, reg_rd, reg_wdata,
        input  reg_rdata, reg_rvalid
    );

    modport slave (
        input  reg_addr, reg_wr, reg_rd, reg_wdata,
        output reg_rdata, reg_rvalid
    );

endinterface
`default_nettype wire

// File: rtl/i2c_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sync_fifo
// Description : Pointer-based synchronous FIFO with a combinational head.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              i_push,
    input  wire              i_pop,
    input  wire [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_push_ok
);

    localparam int             c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]  c_full = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_pop_ok;

    assign o_full   = (r_count == c_full);
    assign o_empty  = (r_count == '0);
    assign o_head   = r_mem[r_rd_ptr];
    assign w_pop_ok = i_pop & ~o_empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign o_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (o_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (o_push_ok) begin
                r_wr_ptr <= r_wr_ptr + (c_aw)'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + (c_aw)'(1);
            end
            if (o_push_ok && !w_pop_ok) begin
                r_count <= r_count + (c_aw + 1)'(1);
            end else if (!o_push_ok && w_pop_ok) begin
                r_count <= r_count - (c_aw + 1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_native_register_file.sv
`default_nettype none
// ============================================================================
// Module      : i2c_native_register_file
// Description : Register file between the host bus adapter and the I2C master
//               core: data FIFOs, sticky W1C status, byte counters and irq.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_native_register_file
    import i2c_regfile_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int LEN_W    = 32,
    parameter int DIV_W    = 16,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  wire                         clk,
    input  wire                         reset,
    i2c_native_register_file_if.slave   bus,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_valid,
    input  wire                         tx_pop,
    input  wire  [DATA_W-1:0]           rx_data,
    input  wire                         rx_push,
    output logic [LEN_W-1:0]            read_length,
    output logic [LEN_W-1:0]            write_length,
    output logic [DIV_W-1:0]            clk_divider,
    output logic [5:0]                  cfg,
    input  wire                         start_ack,
    input  wire                         ev_stop,
    input  wire                         ev_slave_ack,
    input  wire                         ev_slave_nack,
    input  wire                         ev_arb_loss,
    input  wire                         bus_available,
    output logic                        irq
);

    logic [LEN_W-1:0]  r_read_len;
    logic [LEN_W-1:0]  r_write_len;
    logic [DIV_W-1:0]  r_clk_div;
    logic [7:0]        r_ire;
    cfg_t              r_cfg;
    logic              r_stop, r_slave_ack, r_slave_nack, r_arb_loss;
    logic              r_rx_overrun, r_tx_overflow;
    logic [LEN_W-1:0]  r_bytes_rd;
    logic [LEN_W-1:0]  r_bytes_wr;
    logic [31:0]       r_rdata;
    logic              r_rvalid;
    logic              r_irq;

    logic              w_wr_data, w_wr_cfg, w_wr_status, w_rd_data, w_start_set;
    logic              w_tx_full, w_tx_empty, w_tx_push_ok, w_tx_pop_ok;
    logic              w_rx_full, w_rx_empty, w_rx_push_ok;
    logic [DATA_W-1:0] w_rx_head;
    logic [31:0]       w_status;
    logic [31:0]       w_rdata;
    logic [31:0]       w_clr;

    assign w_wr_data   = bus.reg_wr & (bus.reg_addr == c_addr_data);
    assign w_wr_cfg    = bus.reg_wr & (bus.reg_addr == c_addr_config);
    assign w_wr_status = bus.reg_wr & (bus.reg_addr == c_addr_status);
    assign w_rd_data   = bus.reg_rd & (bus.reg_addr == c_addr_data);
    assign w_start_set = w_wr_cfg & bus.reg_wdata[c_cfg_start];
    assign w_tx_pop_ok = tx_pop & ~w_tx_empty;
    assign w_clr       = w_wr_status ? bus.reg_wdata : 32'd0;

    i2c_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_push    (w_wr_data),
        .i_pop     (tx_pop),
        .i_wdata   (bus.reg_wdata[DATA_W-1:0]),
        .o_head    (tx_data),
        .o_full    (w_tx_full),
        .o_empty   (w_tx_empty),
        .o_push_ok (w_tx_push_ok)
    );

    i2c_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_push    (rx_push),
        .i_pop     (w_rd_data),
        .i_wdata   (rx_data),
        .o_head    (w_rx_head),
        .o_full    (w_rx_full),
        .o_empty   (w_rx_empty),
        .o_push_ok (w_rx_push_ok)
    );

    always_comb begin
        w_status                   = '0;
        w_status[c_st_stop]        = r_stop;
        w_status[c_st_din_full]    = w_rx_full;
        w_status[c_st_din_empty]   = w_rx_empty;
        w_status[c_st_dout_full]   = w_tx_full;
        w_status[c_st_slave_ack]   = r_slave_ack;
        w_status[c_st_slave_nack]  = r_slave_nack;
        w_status[c_st_bus_avail]   = bus_available;
        w_status[c_st_arb_loss]    = r_arb_loss;
        w_status[c_st_rx_overrun]  = r_rx_overrun;
        w_status[c_st_tx_overflow] = r_tx_overflow;
    end

    always_comb begin
        w_rdata = '0;
        case (bus.reg_addr)
            c_addr_data:      w_rdata[DATA_W-1:0] = w_rx_empty ? '0 : w_rx_head;
            c_addr_read_len:  w_rdata[LEN_W-1:0]  = r_read_len;
            c_addr_write_len: w_rdata[LEN_W-1:0]  = r_write_len;
            c_addr_clk_div:   w_rdata[DIV_W-1:0]  = r_clk_div;
            c_addr_config:    w_rdata[13:0]       = {r_cfg, r_ire};
            c_addr_status:    w_rdata             = w_status;
            c_addr_bytes_rd:  w_rdata[LEN_W-1:0]  = r_bytes_rd;
            c_addr_bytes_wr:  w_rdata[LEN_W-1:0]  = r_bytes_wr;
            default:          w_rdata             = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_len    <= '0;
            r_write_len   <= '0;
            r_clk_div     <= '0;
            r_ire         <= '0;
            r_cfg         <= '0;
            r_stop        <= 1'b0;
            r_slave_ack   <= 1'b0;
            r_slave_nack  <= 1'b0;
            r_arb_loss    <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_tx_overflow <= 1'b0;
            r_bytes_rd    <= '0;
            r_bytes_wr    <= '0;
            r_rdata       <= '0;
            r_rvalid      <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_rvalid <= bus.reg_rd;
            if (bus.reg_rd) begin
                r_rdata <= w_rdata;
            end
            if (bus.reg_wr && bus.reg_addr == c_addr_read_len) begin
                r_read_len <= bus.reg_wdata[LEN_W-1:0];
            end
            if (bus.reg_wr && bus.reg_addr == c_addr_write_len) begin
                r_write_len <= bus.reg_wdata[LEN_W-1:0];
            end
            if (bus.reg_wr && bus.reg_addr == c_addr_clk_div) begin
                r_clk_div <= bus.reg_wdata[DIV_W-1:0];
            end
            if (w_wr_cfg) begin
                r_ire             <= bus.reg_wdata[7:0];
                r_cfg.fifo_enable <= bus.reg_wdata[c_cfg_fifo_enable];
                r_cfg.packet_type <= bus.reg_wdata[c_cfg_packet_type];
                r_cfg.master_ack  <= bus.reg_wdata[c_cfg_master_ack];
                r_cfg.master_nack <= bus.reg_wdata[c_cfg_master_nack];
                r_cfg.sr_enable   <= bus.reg_wdata[c_cfg_sr_enable];
            end
            // Writing 0 to the start bit leaves it alone; only the core's ack clears it.
            if (w_start_set) begin
                r_cfg.start <= 1'b1;
            end else if (start_ack) begin
                r_cfg.start <= 1'b0;
            end

            // Events are OR'ed in after the clear so a coincident event wins.
            r_stop        <= ev_stop       | (r_stop        & ~w_clr[c_st_stop]);
            r_slave_ack   <= ev_slave_ack  | (r_slave_ack   & ~w_clr[c_st_slave_ack]);
            r_slave_nack  <= ev_slave_nack | (r_slave_nack  & ~w_clr[c_st_slave_nack]);
            r_arb_loss    <= ev_arb_loss   | (r_arb_loss    & ~w_clr[c_st_arb_loss]);
            r_rx_overrun  <= (rx_push & ~w_rx_push_ok)
                           | (r_rx_overrun  & ~w_clr[c_st_rx_overrun]);
            r_tx_overflow <= (w_wr_data & ~w_tx_push_ok)
                           | (r_tx_overflow & ~w_clr[c_st_tx_overflow]);

            if (w_start_set) begin
                r_bytes_rd <= '0;
                r_bytes_wr <= '0;
            end else begin
                if (w_rx_push_ok && !(&r_bytes_rd)) begin
                    r_bytes_rd <= r_bytes_rd + (LEN_W)'(1);
                end
                if (w_tx_pop_ok && !(&r_bytes_wr)) begin
                    r_bytes_wr <= r_bytes_wr + (LEN_W)'(1);
                end
            end

            r_irq <= |(r_ire & w_status[7:0]);
        end
    end

    assign bus.reg_rdata  = r_rdata;
    assign bus.reg_rvalid = r_rvalid;
    assign tx_valid       = ~w_tx_empty;
    assign read_length    = r_read_len;
    assign write_length   = r_write_len;
    assign clk_divider    = r_clk_div;
    assign cfg            = r_cfg;
    assign irq            = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_i2c_native_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_native_register_file
// Description : Directed bench with a queue-based reference model of the
//               register file, checked every cycle plus literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_native_register_file;

    localparam int DATA_W   = 8;
    localparam int LEN_W    = 32;
    localparam int DIV_W    = 16;
    localparam int TX_DEPTH = 4;
    localparam int RX_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_pop;
    logic [DATA_W-1:0] rx_data;
    logic              rx_push;
    logic [LEN_W-1:0]  read_length;
    logic [LEN_W-1:0]  write_length;
    logic [DIV_W-1:0]  clk_divider;
    logic [5:0]        cfg;
    logic              start_ack;
    logic              ev_stop, ev_slave_ack, ev_slave_nack, ev_arb_loss;
    logic              bus_available;
    logic              irq;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    i2c_native_register_file_if bus ();

    i2c_native_register_file #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .DIV_W(DIV_W),
        .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_pop        (tx_pop),
        .rx_data       (rx_data),
        .rx_push       (rx_push),
        .read_length   (read_length),
        .write_length  (write_length),
        .clk_divider   (clk_divider),
        .cfg           (cfg),
        .start_ack     (start_ack),
        .ev_stop       (ev_stop),
        .ev_slave_ack  (ev_slave_ack),
        .ev_slave_nack (ev_slave_nack),
        .ev_arb_loss   (ev_arb_loss),
        .bus_available (bus_available),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues, registers as plain variables.
    logic [DATA_W-1:0] q_tx[$];
    logic [DATA_W-1:0] q_rx[$];
    logic [7:0]        m_ire;
    logic [5:0]        m_cfg;
    logic [LEN_W-1:0]  m_rlen, m_wlen, m_br, m_bw;
    logic [DIV_W-1:0]  m_div;
    logic              m_stop, m_sack, m_snack, m_arb, m_ovr, m_ovf;
    logic [31:0]       m_rdata;
    logic              m_rvalid, m_irq;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'd0;
        s[0] = m_stop;
        s[1] = (q_rx.size() == RX_DEPTH);
        s[2] = (q_rx.size() == 0);
        s[3] = (q_tx.size() == TX_DEPTH);
        s[4] = m_sack;
        s[5] = m_snack;
        s[6] = bus_available;
        s[7] = m_arb;
        s[8] = m_ovr;
        s[9] = m_ovf;
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] v;
        v = 32'd0;
        case (a)
            3'd0: v = (q_rx.size() > 0) ? 32'(q_rx[0]) : 32'd0;
            3'd1: v = 32'(m_rlen);
            3'd2: v = 32'(m_wlen);
            3'd3: v = 32'(m_div);
            3'd4: v = {18'd0, m_cfg, m_ire};
            3'd5: v = m_status();
            3'd6: v = 32'(m_br);
            default: v = 32'(m_bw);
        endcase
        return v;
    endfunction

    always @(posedge clk) begin : p_model
        logic [31:0] st, wd, clr;
        logic        nirq, rx_full, tx_full, rxp, txp, set_ovr, set_ovf, wr_cfg;
        if (reset) begin
            q_tx.delete(); q_rx.delete();
            m_ire = 0; m_cfg = 0; m_rlen = 0; m_wlen = 0; m_br = 0; m_bw = 0; m_div = 0;
            m_stop = 0; m_sack = 0; m_snack = 0; m_arb = 0; m_ovr = 0; m_ovf = 0;
            m_rdata = 0; m_rvalid = 0; m_irq = 0;
            started = 1'b1;
        end else if (started) begin
            wd   = bus.reg_wdata;
            st   = m_status();
            nirq = |(m_ire & st[7:0]);
            m_rvalid = bus.reg_rd;
            if (bus.reg_rd) m_rdata = m_read(bus.reg_addr);

            set_ovr = 0; set_ovf = 0;
            rx_full = (q_rx.size() == RX_DEPTH);
            rxp = bus.reg_rd && bus.reg_addr == 3'd0 && q_rx.size() > 0;
            if (rxp) void'(q_rx.pop_front());
            if (rx_push) begin
                if (!rx_full || rxp) begin
                    q_rx.push_back(rx_data);
                    if (m_br != '1) m_br = m_br + 1;
                end else set_ovr = 1;
            end
            tx_full = (q_tx.size() == TX_DEPTH);
            txp = tx_pop && q_tx.size() > 0;
            if (txp) begin
                void'(q_tx.pop_front());
                if (m_bw != '1) m_bw = m_bw + 1;
            end
            if (bus.reg_wr && bus.reg_addr == 3'd0) begin
                if (!tx_full || txp) q_tx.push_back(wd[DATA_W-1:0]);
                else set_ovf = 1;
            end

            if (bus.reg_wr && bus.reg_addr == 3'd1) m_rlen = wd[LEN_W-1:0];
            if (bus.reg_wr && bus.reg_addr == 3'd2) m_wlen = wd[LEN_W-1:0];
            if (bus.reg_wr && bus.reg_addr == 3'd3) m_div  = wd[DIV_W-1:0];
            wr_cfg = bus.reg_wr && bus.reg_addr == 3'd4;
            if (wr_cfg) begin
                m_ire      = wd[7:0];
                m_cfg[5:3] = wd[13:11];
                m_cfg[1:0] = wd[9:8];
            end
            if (wr_cfg && wd[10]) begin
                m_cfg[2] = 1; m_br = 0; m_bw = 0;
            end else if (start_ack) m_cfg[2] = 0;

            clr = (bus.reg_wr && bus.reg_addr == 3'd5) ? wd : 32'd0;
            m_stop  = (m_stop  & ~clr[0]) | ev_stop;
            m_sack  = (m_sack  & ~clr[4]) | ev_slave_ack;
            m_snack = (m_snack & ~clr[5]) | ev_slave_nack;
            m_arb   = (m_arb   & ~clr[7]) | ev_arb_loss;
            m_ovr   = (m_ovr   & ~clr[8]) | set_ovr;
            m_ovf   = (m_ovf   & ~clr[9]) | set_ovf;
            m_irq   = nirq;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("tx_valid", 32'(tx_valid), 32'(q_tx.size() > 0));
            if (q_tx.size() > 0) chk("tx_data", 32'(tx_data), 32'(q_tx[0]));
            chk("irq", 32'(irq), 32'(m_irq));
            chk("rvalid", 32'(bus.reg_rvalid), 32'(m_rvalid));
            if (m_rvalid) chk("rdata", bus.reg_rdata, m_rdata);
            chk("cfg", 32'(cfg), 32'(m_cfg));
            chk("read_length", read_length, m_rlen);
            chk("write_length", write_length, m_wlen);
            chk("clk_divider", 32'(clk_divider), 32'(m_div));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.reg_addr = a; bus.reg_wdata = d; bus.reg_wr = 1'b1;
        step();
        bus.reg_wr = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.reg_addr = a; bus.reg_rd = 1'b1;
        step();
        bus.reg_rd = 1'b0;
        d = bus.reg_rdata;
    endtask

    initial begin
        logic [31:0] d;
        reset = 1; tx_pop = 0; rx_data = 0; rx_push = 0; start_ack = 0;
        ev_stop = 0; ev_slave_ack = 0; ev_slave_nack = 0; ev_arb_loss = 0;
        bus_available = 0;
        bus.reg_addr = 0; bus.reg_wr = 0; bus.reg_rd = 0; bus.reg_wdata = 0;
        repeat (3) step();
        reset = 0;

        rd(3'd5, d); chk("reset_status", d, 32'h004);
        rd(3'd4, d); chk("reset_config", d, 32'h0);
        chk("reset_tx_valid", 32'(tx_valid), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);

        for (int i = 0; i < 5; i++) wr(3'd0, 32'h11 + i);
        rd(3'd5, d); chk("tx_overflow_status", d, 32'h20C);
        tx_pop = 1;
        for (int i = 0; i < 4; i++) begin
            chk("tx_head", 32'(tx_data), 32'h11 + i);
            step();
        end
        step();
        tx_pop = 0;
        rd(3'd7, d); chk("bytes_written", d, 32'd4);
        chk("model_bytes_written", m_bw, 32'd4);
        wr(3'd5, 32'h200);

        rx_push = 1;
        for (int i = 0; i < 5; i++) begin
            rx_data = 8'hA0 + 8'(i);
            step();
        end
        rx_push = 0;
        rd(3'd5, d); chk("rx_overrun_status", d, 32'h102);
        for (int i = 0; i < 4; i++) begin
            rd(3'd0, d); chk("rx_drain", d, 32'hA0 + i);
        end
        rd(3'd0, d); chk("rx_empty_read", d, 32'h0);
        rd(3'd5, d); chk("rx_drained_status", d, 32'h104);
        rd(3'd6, d); chk("bytes_read", d, 32'd4);
        wr(3'd5, 32'h100);

        rx_data = 8'h5A; rx_push = 1;
        rd(3'd0, d); chk("push_pop_empty", d, 32'h0);
        rx_push = 0;
        rd(3'd0, d); chk("push_pop_empty_data", d, 32'h5A);
        chk("model_rx_empty", 32'(q_rx.size()), 32'd0);

        ev_slave_nack = 1; step(); ev_slave_nack = 0;
        ev_slave_nack = 1; wr(3'd5, 32'h20); ev_slave_nack = 0;
        rd(3'd5, d); chk("w1c_set_wins", d, 32'h024);
        wr(3'd5, 32'h20);
        rd(3'd5, d); chk("w1c_clear", d, 32'h004);
        bus_available = 1;
        rd(3'd5, d); chk("bus_available", d, 32'h044);
        bus_available = 0;

        wr(3'd1, 32'hDEADBEEF);
        wr(3'd3, 32'h12345678);
        chk("clk_div_lsbs", 32'(clk_divider), 32'h5678);
        rd(3'd3, d); chk("clk_div_read", d, 32'h5678);

        wr(3'd4, 32'h400);
        rd(3'd4, d); chk("start_config", d, 32'h400);
        chk("start_cfg", 32'(cfg), 32'h04);
        rd(3'd6, d); chk("start_clears_br", d, 32'd0);
        rd(3'd7, d); chk("start_clears_bw", d, 32'd0);
        start_ack = 1; step(); start_ack = 0;
        chk("start_ack_clears", 32'(cfg), 32'h0);
        start_ack = 1; wr(3'd4, 32'h400); start_ack = 0;
        chk("start_set_wins", 32'(cfg), 32'h04);
        start_ack = 1; step(); start_ack = 0;

        wr(3'd4, 32'h01);
        ev_stop = 1; step(); ev_stop = 0;
        chk("irq_not_yet", 32'(irq), 32'd0);
        step();
        chk("irq_asserted", 32'(irq), 32'd1);
        wr(3'd5, 32'h01);
        chk("irq_lags_clear", 32'(irq), 32'd1);
        step();
        chk("irq_cleared", 32'(irq), 32'd0);

        wr(3'd0, 32'h77);
        bus.reg_addr = 3'd0; bus.reg_wdata = 32'h88; bus.reg_wr = 1; reset = 1;
        step();
        bus.reg_wr = 0; reset = 0;
        chk("reset_mid_tx_valid", 32'(tx_valid), 32'd0);
        rd(3'd5, d); chk("reset_mid_status", d, 32'h004);
        rd(3'd1, d); chk("reset_mid_read_len", d, 32'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
